// File: rtl/tcp_conn_table.sv
// Outbound TCP open/close broker: arbitrates region requests to the stack and keeps
// the session-id -> {vfid, route_id} table that steers RX data per session.

module tcp_conn_rr_arb #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic         aclk,
  input  logic         areset,
  input  logic [N-1:0] req,
  input  logic         adv,
  output logic [W-1:0] gnt,
  output logic         any
);
  logic [W-1:0] ptr;

  // search starts one past the last winner
  always_comb begin
    logic         found;
    logic [W-1:0] idx;
    found = 1'b0;
    idx   = '0;
    gnt   = '0;
    for (int i = 1; i <= N; i++) begin
      idx = W'((int'(ptr) + i) % N);
      if (!found && req[idx]) begin
        gnt   = idx;
        found = 1'b1;
      end
    end
  end

  assign any = |req;

  always_ff @(posedge aclk or posedge areset)
    if (areset)   ptr <= W'(N - 1);
    else if (adv) ptr <= gnt;
endmodule

module tcp_conn_table #(
  parameter  int N_REGIONS  = 4,
  parameter  int SID_BITS   = 10,
  parameter  int ROUTE_BITS = 14,
  localparam int NRB        = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [N_REGIONS-1:0]          s_open_req_valid,
  output logic [N_REGIONS-1:0]          s_open_req_ready,
  input  logic [N_REGIONS-1:0][61:0]    s_open_req_data,
  input  logic [N_REGIONS-1:0]          s_close_req_valid,
  output logic [N_REGIONS-1:0]          s_close_req_ready,
  input  logic [N_REGIONS-1:0][15:0]    s_close_req_data,
  output logic                          m_open_req_valid,
  input  logic                          m_open_req_ready,
  output logic [47:0]                   m_open_req_data,
  input  logic                          s_open_rsp_valid,
  output logic                          s_open_rsp_ready,
  input  logic [64:0]                   s_open_rsp_data,
  output logic [N_REGIONS-1:0]          m_open_rsp_valid,
  input  logic [N_REGIONS-1:0]          m_open_rsp_ready,
  output logic [N_REGIONS-1:0][64:0]    m_open_rsp_data,
  output logic                          m_close_req_valid,
  input  logic                          m_close_req_ready,
  output logic [15:0]                   m_close_req_data,
  output logic                          close_reject,
  input  logic [15:0]                   sid_addr,
  output logic                          hit_out,
  output logic [NRB-1:0]                vfid_out,
  output logic [ROUTE_BITS-1:0]         route_id_out
);
  localparam int EW = NRB + ROUTE_BITS;
  localparam int NE = 1 << SID_BITS;

  typedef enum logic [2:0] {
    ST_IDLE, ST_OPEN_SEND, ST_OPEN_WAIT, ST_OPEN_RSP, ST_CLOSE_LK, ST_CLOSE_W, ST_CLOSE_SEND
  } state_t;

  state_t              state, state_nx;
  logic [NRB-1:0]      og, cg, vfid_q;
  logic                o_any, c_any, o_acc, c_acc;
  logic [61:0]         req_q;
  logic [64:0]         rsp_q;
  logic                tbl_we, tbl_clr;
  logic [SID_BITS-1:0] wsid, csid, lsid;
  logic [NE-1:0]       vld;
  logic [EW-1:0]       mem [NE];
  logic [1:0]          hit_pipe;
  logic [EW-1:0]       lk_e1, lk_e2, ce_q;
  logic                cv_q;
  logic                unused_bits;

  tcp_conn_rr_arb #(.N(N_REGIONS), .W(NRB)) u_open_arb (
    .aclk(aclk), .areset(areset), .req(s_open_req_valid), .adv(o_acc), .gnt(og), .any(o_any));
  tcp_conn_rr_arb #(.N(N_REGIONS), .W(NRB)) u_close_arb (
    .aclk(aclk), .areset(areset), .req(s_close_req_valid), .adv(c_acc), .gnt(cg), .any(c_any));

  assign wsid = s_open_rsp_data[SID_BITS:1];
  assign csid = req_q[SID_BITS-1:0];
  assign lsid = sid_addr[SID_BITS-1:0];

  always_comb begin
    state_nx     = state;
    o_acc        = 1'b0;
    c_acc        = 1'b0;
    tbl_we       = 1'b0;
    tbl_clr      = 1'b0;
    close_reject = 1'b0;
    case (state)
      ST_IDLE:
        if (o_any) begin
          o_acc    = 1'b1;
          state_nx = ST_OPEN_SEND;
        end else if (c_any) begin
          c_acc    = 1'b1;
          state_nx = ST_CLOSE_LK;
        end
      ST_OPEN_SEND: if (m_open_req_ready) state_nx = ST_OPEN_WAIT;
      ST_OPEN_WAIT:
        if (s_open_rsp_valid) begin
          tbl_we   = s_open_rsp_data[0];
          state_nx = ST_OPEN_RSP;
        end
      ST_OPEN_RSP:  if (m_open_rsp_ready[vfid_q]) state_nx = ST_IDLE;
      ST_CLOSE_LK:  state_nx = ST_CLOSE_W;
      ST_CLOSE_W:
        if (cv_q && ce_q[EW-1 -: NRB] == vfid_q) begin
          tbl_clr  = 1'b1;
          state_nx = ST_CLOSE_SEND;
        end else begin
          close_reject = 1'b1;
          state_nx     = ST_IDLE;
        end
      ST_CLOSE_SEND: if (m_close_req_ready) state_nx = ST_IDLE;
      default:       state_nx = ST_IDLE;
    endcase
  end

  assign s_open_req_ready  = o_acc ? (N_REGIONS'(1) << og) : '0;
  assign s_close_req_ready = c_acc ? (N_REGIONS'(1) << cg) : '0;
  assign m_open_req_valid  = (state == ST_OPEN_SEND);
  assign m_open_req_data   = req_q[47:0];
  assign s_open_rsp_ready  = (state == ST_OPEN_WAIT);
  assign m_open_rsp_valid  = (state == ST_OPEN_RSP) ? (N_REGIONS'(1) << vfid_q) : '0;
  assign m_open_rsp_data   = {N_REGIONS{rsp_q}};
  assign m_close_req_valid = (state == ST_CLOSE_SEND);
  assign m_close_req_data  = req_q[15:0];

  // close requests reuse req_q with the sid in the low bits
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      state  <= ST_IDLE;
      vfid_q <= '0;
      req_q  <= '0;
      rsp_q  <= '0;
    end else begin
      state <= state_nx;
      if (o_acc) begin
        vfid_q <= og;
        req_q  <= s_open_req_data[og];
      end else if (c_acc) begin
        vfid_q <= cg;
        req_q  <= {46'b0, s_close_req_data[cg]};
      end
      if (state == ST_OPEN_WAIT && s_open_rsp_valid) rsp_q <= s_open_rsp_data;
    end

  always_ff @(posedge aclk or posedge areset)
    if (areset)       vld       <= '0;
    else if (tbl_we)  vld[wsid] <= 1'b1;
    else if (tbl_clr) vld[csid] <= 1'b0;

  always_ff @(posedge aclk)
    if (tbl_we) mem[wsid] <= {vfid_q, ROUTE_BITS'(req_q[61:48])};

  // both read ports sample before this edge's write lands, giving read-first
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      hit_pipe <= '0;
      lk_e1    <= '0;
      lk_e2    <= '0;
      cv_q     <= 1'b0;
      ce_q     <= '0;
    end else begin
      hit_pipe <= {hit_pipe[0], vld[lsid]};
      lk_e1    <= mem[lsid];
      lk_e2    <= lk_e1;
      cv_q     <= vld[csid];
      ce_q     <= mem[csid];
    end

  assign hit_out      = hit_pipe[1];
  assign vfid_out     = lk_e2[EW-1 -: NRB];
  assign route_id_out = lk_e2[ROUTE_BITS-1:0];
  assign unused_bits  = ^{sid_addr[15:SID_BITS], ce_q[ROUTE_BITS-1:0]};
endmodule
